// File: rtl/iob_eth_mem_arbiter.sv
// ---------------------------------------------------------------------------
// iob_eth_mem_arbiter
//   Round-robin arbiter sharing one system-memory IOb port between the CPU
//   data master (m0) and the Ethernet MAC DMA master (m1). The grant is held
//   for a whole transaction. A watchdog completes a transaction that the
//   memory never acknowledges.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   m0_* / m1_*         IOb slave ports facing the CPU and the MAC DMA
//   mem_*               IOb master port facing memory / interconnect
//   busy_o              high while a transaction is outstanding
//   timeout_o           one-cycle pulse when the watchdog aborts a transaction
//
// States:
//   state | meaning
//   IDLE  | no transaction outstanding, arbitrating between m0 and m1
//   BUSY  | mem_* carries the granted request, waiting for mem_ready
// ---------------------------------------------------------------------------
module iob_eth_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 12
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,

    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,

    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,

    output logic                busy_o,
    output logic                timeout_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;            // 0 = m0, 1 = m1
    logic                  last_grant_q, last_grant_d;
    logic [TIMEOUT_W-1:0]  watchdog_q, watchdog_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]     mem_address_q, mem_address_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic [TIMEOUT_W-1:0]  watchdog_inc;
    logic                  watchdog_tc;
    logic                  done;
    logic                  abort;
    logic                  ready_any;

    // The watchdog holds the number of completed BUSY cycles, so the abort
    // fires in the BUSY cycle whose increment would reach all-ones, i.e. the
    // (2^TIMEOUT_W-1)-th cycle without mem_ready.
    assign watchdog_inc = watchdog_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    assign watchdog_tc  = &watchdog_inc;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        watchdog_d    = watchdog_q;
        mem_valid_d   = mem_valid_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        done          = 1'b0;
        abort         = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // Contention goes to whoever did not win last time.
                    grant_d       = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
                    last_grant_d  = grant_d;
                    mem_valid_d   = 1'b1;
                    mem_address_d = grant_d ? m1_address : m0_address;
                    mem_wdata_d   = grant_d ? m1_wdata   : m0_wdata;
                    mem_wstrb_d   = grant_d ? m1_wstrb   : m0_wstrb;
                    watchdog_d    = '0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    // A real completion beats a coincident terminal count.
                    done = 1'b1;
                end else if (watchdog_tc) begin
                    abort = 1'b1;
                end else begin
                    watchdog_d = watchdog_inc;
                end
                if (done || abort) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = '0;
                    watchdog_d  = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset edge terminates the transaction silently, so completions are
    // masked while rst is asserted.
    assign ready_any = (done || abort) && !rst;

    assign m0_ready  = ready_any && !grant_q;
    assign m1_ready  = ready_any &&  grant_q;
    assign m0_rdata  = (m0_ready && done) ? mem_rdata : '0;
    assign m1_rdata  = (m1_ready && done) ? mem_rdata : '0;
    assign timeout_o = abort && !rst;

    assign mem_valid   = mem_valid_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign busy_o      = (state_q == BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            watchdog_q    <= '0;
            mem_valid_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            watchdog_q    <= watchdog_d;
            mem_valid_q   <= mem_valid_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
        end
    end

endmodule

// File: tb/tb_iob_eth_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iob_eth_mem_arbiter
//   Self-checking bench for iob_eth_mem_arbiter (TIMEOUT_W = 4). A
//   transaction-level reference model (who owns memory, how many BUSY cycles
//   have elapsed) predicts every output each cycle. Directed scenarios are
//   followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_iob_eth_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int TW   = 4;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_address, m1_address;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [SW-1:0] m0_wstrb, m1_wstrb;
    logic          m0_ready, m1_ready;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_wstrb;
    logic          busy_o, timeout_o;

    always #5 clk = ~clk;

    iob_eth_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_address(m0_address), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_address(m1_address), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .mem_valid(mem_valid), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    // bench-side masters
    bit            pend[2];
    bit            cool[2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_wdata[2];
    logic [SW-1:0] p_wstrb[2];
    int            auto_pct;

    // reference model: memory ownership at transaction level
    bit            mb;        // a transaction is outstanding
    int            mown;      // owner of the outstanding transaction
    int            mlast;     // master that won most recently
    int            mcnt;      // index of the current BUSY cycle, 1-based
    logic [AW-1:0] ma;
    logic [DW-1:0] mw;
    logic [SW-1:0] ms;

    // memory responder: ready in BUSY cycle number mem_lat (never if > TMAX)
    int            mem_lat;
    logic [DW-1:0] rd_val;
    bit            rand_mode;

    int            vectors;
    int            miscompares;
    int            grant_log[$];
    int            to_seen;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] w, input logic [SW-1:0] s);
        pend[i]    = 1'b1;
        p_addr[i]  = a;
        p_wdata[i] = w;
        p_wstrb[i] = s;
    endtask

    // One clock cycle: drive, check mid-cycle, advance the model, wait edge.
    task automatic step(input bit do_rst);
        bit            done, to, r0, r1;
        int            own;
        logic [DW-1:0] rdv;
        for (int i = 0; i < 2; i++) begin
            if (auto_pct > 0 && !pend[i]) begin
                if (cool[i]) cool[i] = 1'b0;
                else if (($urandom % 100) < auto_pct)
                    req(i, $urandom, $urandom, ($urandom % 2) ? 4'h0 : 4'($urandom));
            end
        end
        rst        = do_rst;
        m0_valid   = pend[0];
        m0_address = p_addr[0];
        m0_wdata   = p_wdata[0];
        m0_wstrb   = p_wstrb[0];
        m1_valid   = pend[1];
        m1_address = p_addr[1];
        m1_wdata   = p_wdata[1];
        m1_wstrb   = p_wstrb[1];
        rdv        = rand_mode ? DW'($urandom) : rd_val;
        mem_rdata  = rdv;
        mem_ready  = mb && (mcnt == mem_lat) && !do_rst;
        #4;
        if (do_rst) begin
            check_val("rst_m0_ready", m0_ready, 0);
            check_val("rst_m1_ready", m1_ready, 0);
            check_val("rst_timeout", timeout_o, 0);
            mb    = 1'b0;
            mlast = 1;
            pend  = '{default: 1'b0};
            cool  = '{default: 1'b0};
        end else begin
            done = mem_ready;
            to   = mb && !done && (mcnt == TMAX);
            r0   = mb && (mown == 0) && (done || to);
            r1   = mb && (mown == 1) && (done || to);
            check_val("mem_valid", mem_valid, mb);
            check_val("busy_o", busy_o, mb);
            check_val("timeout_o", timeout_o, to);
            check_val("m0_ready", m0_ready, r0);
            check_val("m1_ready", m1_ready, r1);
            check_val("m0_rdata", m0_rdata, (r0 && done) ? rdv : 0);
            check_val("m1_rdata", m1_rdata, (r1 && done) ? rdv : 0);
            if (mb) begin
                check_val("mem_address", mem_address, ma);
                check_val("mem_wdata", mem_wdata, mw);
                check_val("mem_wstrb", mem_wstrb, ms);
            end
            if (r0 || r1) begin
                grant_log.push_back(mown);
                pend[mown] = 1'b0;
                cool[mown] = 1'b1;
                if (to) to_seen++;
            end
            if (mb) begin
                if (done || to) mb = 1'b0;
                else mcnt++;
            end else if (m0_valid || m1_valid) begin
                if (m0_valid && m1_valid) own = 1 - mlast;
                else own = m0_valid ? 0 : 1;
                mown  = own;
                mlast = own;
                mb    = 1'b1;
                mcnt  = 1;
                ma    = p_addr[own];
                mw    = p_wdata[own];
                ms    = p_wstrb[own];
                if (rand_mode) begin
                    case ($urandom % 10)
                        0:       mem_lat = 100;
                        1:       mem_lat = TMAX;
                        default: mem_lat = 1 + int'($urandom % 6);
                    endcase
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle();
        int n = 0;
        while ((mb || pend[0] || pend[1]) && n < 200) begin
            step(1'b0);
            n++;
        end
        check_val("idle_bound", (n < 200), 1);
    endtask

    initial begin
        int n;
        int to_before;
        vectors = 0; miscompares = 0; to_seen = 0;
        auto_pct = 0; rand_mode = 1'b0; mem_lat = 1; rd_val = '0;
        pend = '{default: 1'b0}; cool = '{default: 1'b0};
        p_addr = '{default: '0}; p_wdata = '{default: '0}; p_wstrb = '{default: '0};
        mb = 1'b0; mlast = 1; mown = 0; mcnt = 0;
        rst = 1'b1; m0_valid = 0; m1_valid = 0; mem_ready = 0; mem_rdata = '0;
        m0_address = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_address = '0; m1_wdata = '0; m1_wstrb = '0;
        @(posedge clk); #1;
        step(1'b1);
        step(1'b1);

        check_val("reset_mem_valid", mem_valid, 0);
        check_val("reset_mem_address", mem_address, 0);
        check_val("reset_mem_wdata", mem_wdata, 0);
        check_val("reset_mem_wstrb", mem_wstrb, 0);
        check_val("reset_busy", busy_o, 0);

        // single read from m0
        mem_lat = 2; rd_val = 32'hCAFEF00D;
        req(0, 32'h100, 32'h0, 4'h0);
        step(1'b0);
        check_val("read_lat_mem_valid", mem_valid, 1);
        check_val("read_addr", mem_address, 32'h100);
        run_until_idle();

        // single write from m1
        mem_lat = 1;
        req(1, 32'h2000, 32'h12345678, 4'hF);
        run_until_idle();

        // contention: strict alternation starting with m0
        grant_log.delete();
        auto_pct = 100;
        n = 0;
        while (grant_log.size() < 8 && n < 300) begin
            step(1'b0);
            n++;
        end
        auto_pct = 0;
        run_until_idle();
        check_val("alt_count", (grant_log.size() >= 8), 1);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check_val($sformatf("alt_grant%0d", k), grant_log[k], k % 2);

        // memory never answers: watchdog abort, then a normal transaction
        to_before = to_seen;
        mem_lat = 100;
        req(0, 32'h300, 32'h0, 4'h0);
        run_until_idle();
        check_val("timeout_count", to_seen - to_before, 1);
        mem_lat = 3; rd_val = 32'h0BADBEEF;
        req(0, 32'h304, 32'h0, 4'h0);
        run_until_idle();
        check_val("after_timeout_count", to_seen - to_before, 1);

        // mem_ready exactly at the terminal count wins
        mem_lat = TMAX; rd_val = 32'hA5A55A5A;
        req(1, 32'h400, 32'h0, 4'h0);
        run_until_idle();
        check_val("tc_no_timeout", to_seen - to_before, 1);

        // reset in the middle of a transaction
        mem_lat = 100;
        req(0, 32'h500, 32'h0, 4'h0);
        for (int k = 0; k < 5; k++) step(1'b0);
        check_val("pre_rst_busy", busy_o, 1);
        step(1'b1);
        check_val("post_rst_mem_valid", mem_valid, 0);
        check_val("post_rst_busy", busy_o, 0);
        mem_lat = 2; rd_val = 32'h11223344;
        req(1, 32'h600, 32'h55, 4'h3);
        run_until_idle();
        step(1'b1);
        grant_log.delete();
        req(0, 32'h700, 32'h0, 4'h0);
        req(1, 32'h704, 32'h0, 4'h0);
        run_until_idle();
        check_val("rst_priority_m0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // randomized traffic with occasional resets
        rand_mode = 1'b1;
        auto_pct  = 30;
        for (int k = 0; k < 4000; k++)
            step(($urandom % 700) == 0);
        auto_pct = 0;
        run_until_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iob_eth_mem_arbiter.md
Name: iob_eth_mem_arbiter

Overview:
Two-master IOb arbiter that shares one system-memory IOb port between the CPU data master (m0) and the Ethernet MAC DMA master (m1, driven from the MAC's m_* port).
It sits directly downstream of the MAC's IOb master interface and upstream of the memory/interconnect.
Arbitration is round-robin. The grant is locked for a whole transaction, and a watchdog completes any transaction the memory never acknowledges.

Parameters:
ADDR_W, 32, address width of all three IOb ports
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT_W, 12, watchdog counter width; a transaction aborts after 2^TIMEOUT_W-1 cycles in BUSY without mem_ready

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset (one clock, sync active-high reset)
m0_valid  in  1  CPU request; held until m0_ready
m0_address  in  ADDR_W  CPU address
m0_wdata  in  DATA_W  CPU write data
m0_wstrb  in  DATA_W/8  CPU byte strobes; all-zero means read
m0_rdata  out  DATA_W  CPU read data, valid while m0_ready=1
m0_ready  out  1  one-cycle completion pulse to CPU
m1_valid / m1_address / m1_wdata / m1_wstrb / m1_rdata / m1_ready  same as m0_*, for the MAC DMA master
mem_valid  out  1  memory request
mem_address  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  DATA_W/8  memory strobes
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion pulse
busy_o  out  1  high while in BUSY state
timeout_o  out  1  one-cycle pulse when the watchdog aborts a transaction

Behaviour:
- Reset values: state=IDLE; mem_valid, mem_address, mem_wdata, mem_wstrb = 0; m0_ready, m1_ready, busy_o, timeout_o = 0; last_grant=1, so m0 wins first; watchdog=0.
- Master rule: a master holds valid and its payload stable until it sees ready, then drops valid the next cycle. The arbiter does not check this rule.
- IDLE state:
  - If exactly one valid is high, grant that master.
  - If both are high, grant the master that is not last_grant.
  - On the granting edge: register the granted address, wdata and wstrb onto mem_*; set mem_valid=1, grant, last_grant=grant; go to BUSY.
  - Latency from request valid to mem_valid is 1 cycle.
- BUSY state:
  - mem_* held stable; mem_valid=1.
  - While mem_ready=1: granted mN_ready = 1 combinationally and mN_rdata = mem_rdata. The non-granted ready stays 0.
  - On the edge where mem_ready=1: mem_valid=0, mem_wstrb=0, watchdog=0, go to IDLE.
  - A new grant cannot be issued before the following cycle, so there is one idle cycle between back-to-back transactions.
- rdata muxing: mN_rdata = mem_rdata when mN_ready=1; otherwise 0.
- Watchdog:
  - Increments each BUSY cycle without mem_ready.
  - When it reaches all-ones without mem_ready, the granted mN_ready is driven high for that cycle with mN_rdata=0, and timeout_o pulses.
  - On the next edge: mem_valid=0, go to IDLE.
  - If mem_ready coincides with the terminal count, mem_ready wins: normal completion, timeout_o=0.
- A new request from the non-granted master during BUSY is ignored until IDLE; its ready stays 0.
- Reset mid-transaction: at the reset edge mem_valid drops, state returns to IDLE, and no ready is issued. Masters must also be reset.
- busy_o = (state==BUSY).

Test Plan:
- Single read: m0_valid, address 0x100, wstrb 0 → mem_valid=1 one cycle later with mem_address=0x100, mem_wstrb=0; mem_ready with mem_rdata=0xCAFEF00D → m0_ready=1, m0_rdata=0xCAFEF00D in the same cycle, m1_ready=0.
- Single write from m1: address 0x2000, wdata 0x12345678, wstrb 0xF → mem_* carry those exact values; m1_ready pulses for 1 cycle on mem_ready.
- Simultaneous requests from reset: m0 granted first; after completion, m1 granted on the next IDLE cycle; with both requesting repeatedly, grants alternate m0,m1,m0,m1 over 8 transactions.
- Memory holds mem_ready low: with TIMEOUT_W=4, after 15 BUSY cycles the granted ready=1, rdata=0, timeout_o=1 → IDLE; the next request is serviced normally.
- Ready at terminal count: mem_ready asserted exactly on cycle 15 → normal completion with mem_rdata passed through, timeout_o=0.
- Reset while BUSY with mem_valid=1: assert rst for 1 cycle → mem_valid=0, busy_o=0, no ready pulse; the following m1 request is serviced with m0 priority restored.
